dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single data memory (`dmem`) between the CPU load/store unit and a debug/loader port. The debug/loader port is used for program and data preload and for post-run memory dumps. It sits between `cpu`/debug master and `dmem`, issues at most one access per cycle, and routes read responses back to the originating port. It replaces hierarchical preloading with a bus-level path that the testbench and on-board loader can both drive.

---
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response bundle for one dmem_arbiter requester port
// master = requester side (CPU LSU or debug/loader), slave = arbiter side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output req, we, addr, wdata, wstrb,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, wstrb,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU / debug-loader arbiter in front of the single-ported dmem
// DMEM_ARB_RR_EN selects round-robin; otherwise fixed dbg>cpu priority with MAX_WAIT override.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic                clk,
   input  logic                reset,
   dmem_arbiter_if.slave       cpu,
   dmem_arbiter_if.slave       dbg,
   input  logic                dbg_lock,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [31:0]         cpu_wait_cnt
);

   logic        locked_q, locked_d;
   logic        resp_pend_q, resp_pend_d;
   logic        resp_owner_q, resp_owner_d;
   logic [31:0] cpu_wait_cnt_q, cpu_wait_cnt_d;
`ifdef DMEM_ARB_RR_EN
   logic        rr_dbg_q, rr_dbg_d;
`else
   localparam int WCW = $clog2(MAX_WAIT + 1);
   logic [WCW-1:0] wait_ctr_q, wait_ctr_d;
`endif

   logic lock_active;
   logic contested;
   logic cpu_win;
   logic dbg_win;
   logic win_we;

   always_comb begin
      lock_active = locked_q && dbg_lock;
      contested   = cpu.req && dbg.req;
      cpu_win     = 1'b0;
      dbg_win     = 1'b0;
      if (!reset) begin
         if (lock_active) begin
            dbg_win = dbg.req;
         end else if (contested) begin
`ifdef DMEM_ARB_RR_EN
            dbg_win = rr_dbg_q;
            cpu_win = !rr_dbg_q;
`else
            // A starved CPU overrides dbg priority, but never an active lock.
            cpu_win = (wait_ctr_q == WCW'(MAX_WAIT));
            dbg_win = !cpu_win;
`endif
         end else begin
            cpu_win = cpu.req;
            dbg_win = dbg.req;
         end
      end
      win_we = dbg_win ? dbg.we : cpu.we;
   end

   always_comb begin
      locked_d = locked_q;
      if (!dbg_lock) begin
         locked_d = 1'b0;
      end else if (dbg_win) begin
         locked_d = 1'b1;
      end

      resp_pend_d  = (cpu_win || dbg_win) && !win_we;
      resp_owner_d = dbg_win;

      cpu_wait_cnt_d = cpu_wait_cnt_q;
      if (cpu.req && !cpu_win && (cpu_wait_cnt_q != 32'hFFFF_FFFF)) begin
         cpu_wait_cnt_d = cpu_wait_cnt_q + 32'd1;
      end

`ifdef DMEM_ARB_RR_EN
      rr_dbg_d = rr_dbg_q;
      if (contested && (cpu_win || dbg_win)) begin
         rr_dbg_d = cpu_win;
      end
`else
      wait_ctr_d = wait_ctr_q;
      if (cpu_win) begin
         wait_ctr_d = '0;
      end else if (cpu.req && !lock_active && (wait_ctr_q != WCW'(MAX_WAIT))) begin
         wait_ctr_d = wait_ctr_q + WCW'(1);
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         locked_q       <= 1'b0;
         resp_pend_q    <= 1'b0;
         resp_owner_q   <= 1'b0;
         cpu_wait_cnt_q <= '0;
`ifdef DMEM_ARB_RR_EN
         rr_dbg_q       <= 1'b0;
`else
         wait_ctr_q     <= '0;
`endif
      end else begin
         locked_q       <= locked_d;
         resp_pend_q    <= resp_pend_d;
         resp_owner_q   <= resp_owner_d;
         cpu_wait_cnt_q <= cpu_wait_cnt_d;
`ifdef DMEM_ARB_RR_EN
         rr_dbg_q       <= rr_dbg_d;
`else
         wait_ctr_q     <= wait_ctr_d;
`endif
      end
   end

   assign cpu.gnt      = cpu_win;
   assign dbg.gnt      = dbg_win;

   assign mem_en       = cpu_win || dbg_win;
   assign mem_we       = mem_en && win_we;
   assign mem_addr     = dbg_win ? dbg.addr  : cpu.addr;
   assign mem_wdata    = dbg_win ? dbg.wdata : cpu.wdata;
   assign mem_wstrb    = dbg_win ? dbg.wstrb : cpu.wstrb;

   assign cpu.rvalid   = resp_pend_q && !resp_owner_q;
   assign dbg.rvalid   = resp_pend_q && resp_owner_q;
   assign cpu.rdata    = resp_pend_q ? mem_rdata : '0;
   assign dbg.rdata    = resp_pend_q ? mem_rdata : '0;

   assign cpu_wait_cnt = cpu_wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized + directed bench for dmem_arbiter against a reference model
module tb_dmem_arbiter;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 8;

   logic        clk;
   logic        reset;
   logic        dbg_lock;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] cpu_wait_cnt;

   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu          (cpu_if.slave),
      .dbg          (dbg_if.slave),
      .dbg_lock     (dbg_lock),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_rdata    (mem_rdata),
      .cpu_wait_cnt (cpu_wait_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment: a 16-word synchronous RAM standing in for dmem.
   logic [31:0] ram [0:15];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= ram[mem_addr[5:2]];
         end
      end
   end

   int n_checks;
   int n_fail;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reference model state, kept as plain counters/arrays.
   logic [31:0] exp_mem [0:15];
   bit          m_locked;
   int          m_waited;
   bit          m_favour_dbg;
   int          m_resp;        // 0 none, 1 cpu, 2 dbg
   logic [31:0] m_rdata;
   longint      m_cnt;
   bit          gc, gd;

   task automatic set_port(input bit is_dbg, input bit req, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      if (is_dbg) begin
         dbg_if.req = req; dbg_if.we = we; dbg_if.addr = addr; dbg_if.wdata = wdata; dbg_if.wstrb = wstrb;
      end else begin
         cpu_if.req = req; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.wstrb = wstrb;
      end
   endtask

   task automatic predict(output bit ec, output bit ed);
      bit lk;
      lk = m_locked && dbg_lock;
      ec = 1'b0;
      ed = 1'b0;
      if (lk) begin
         ed = dbg_if.req;
      end else if (cpu_if.req && dbg_if.req) begin
`ifdef DMEM_ARB_RR_EN
         if (m_favour_dbg) ed = 1'b1; else ec = 1'b1;
`else
         if (m_waited >= MAX_WAIT) ec = 1'b1; else ed = 1'b1;
`endif
      end else begin
         ec = cpu_if.req;
         ed = dbg_if.req;
      end
   endtask

   // Called at a negedge with inputs driven; returns at the next negedge.
   task automatic cycle();
      bit ec, ed, lk, wwe;
      logic [31:0] waddr, wdat;
      logic [3:0]  wst;
      #1;
      predict(ec, ed);
      lk = m_locked && dbg_lock;
      check("cpu_gnt", cpu_if.gnt, ec);
      check("dbg_gnt", dbg_if.gnt, ed);
      check("cpu_rvalid", cpu_if.rvalid, m_resp == 1);
      check("dbg_rvalid", dbg_if.rvalid, m_resp == 2);
      if (m_resp == 1) check("cpu_rdata", cpu_if.rdata, m_rdata);
      if (m_resp == 2) check("dbg_rdata", dbg_if.rdata, m_rdata);
      check("mem_en", mem_en, ec | ed);
      wwe = ec ? cpu_if.we : (ed ? dbg_if.we : 1'b0);
      check("mem_we", mem_we, wwe);
      waddr = ed ? dbg_if.addr : cpu_if.addr;
      wdat  = ed ? dbg_if.wdata : cpu_if.wdata;
      wst   = ed ? dbg_if.wstrb : cpu_if.wstrb;
      if (ec | ed) check("mem_addr", mem_addr, waddr);
      check("cpu_wait_cnt", cpu_wait_cnt, m_cnt);
      gc = cpu_if.gnt;
      gd = dbg_if.gnt;

      m_resp = 0;
      if (ec | ed) begin
         if (wwe) begin
            for (int b = 0; b < 4; b++)
               if (wst[b]) exp_mem[waddr[5:2]][8*b +: 8] = wdat[8*b +: 8];
         end else begin
            m_resp  = ec ? 1 : 2;
            m_rdata = exp_mem[waddr[5:2]];
         end
      end
      if (cpu_if.req && dbg_if.req && (ec | ed)) m_favour_dbg = ec;
      if (ec) m_waited = 0;
      else if (cpu_if.req && !lk && m_waited < MAX_WAIT) m_waited++;
      if (cpu_if.req && !ec && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!dbg_lock) m_locked = 1'b0;
      else if (ed) m_locked = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      dbg_lock = 1'b0;
      set_port(0, 1, 0, 32'h0, 32'h0, 4'h0);
      set_port(1, 1, 0, 32'h4, 32'h0, 4'h0);
      #1;
      check("rst_cpu_gnt", cpu_if.gnt, 0);
      check("rst_dbg_gnt", dbg_if.gnt, 0);
      check("rst_cpu_rvalid", cpu_if.rvalid, 0);
      check("rst_dbg_rvalid", dbg_if.rvalid, 0);
      check("rst_cpu_rdata", cpu_if.rdata, 0);
      check("rst_dbg_rdata", dbg_if.rdata, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_wait_cnt", cpu_wait_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
      set_port(1, 0, 0, 32'h0, 32'h0, 4'h0);
      reset = 1'b0;
      m_locked = 0; m_waited = 0; m_favour_dbg = 0; m_resp = 0; m_cnt = 0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 16; i++) begin
         ram[i]     = 32'h1000_0000 + i * 32'h0101_0101;
         exp_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
      end
      mem_rdata = '0;
      @(negedge clk);
      do_reset();

      // Solo CPU write then read.
      set_port(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF); cycle();
      check("solo_wr_gnt", gc, 1);
      set_port(0, 1, 0, 32'h10, 32'h0, 4'h0); cycle();
      check("solo_rd_gnt", gc, 1);
      set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
      #1;
      check("solo_rvalid", cpu_if.rvalid, 1);
      check("solo_rdata", cpu_if.rdata, 32'hDEADBEEF);
      check("solo_dbg_rvalid", dbg_if.rvalid, 0);
      cycle();

      // Byte strobe merge.
      set_port(1, 1, 1, 32'h20, 32'h11223344, 4'hF); cycle();
      set_port(1, 0, 0, 32'h0, 32'h0, 4'h0);
      set_port(0, 1, 1, 32'h20, 32'h000000AA, 4'h1); cycle();
      set_port(0, 1, 0, 32'h20, 32'h0, 4'h0); cycle();
      set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
      #1;
      check("strobe_rdata", cpu_if.rdata, 32'h112233AA);
      cycle();

      // Continuous contention.
      do_reset();
      set_port(0, 1, 0, 32'h10, 32'h0, 4'h0);
      set_port(1, 1, 0, 32'h20, 32'h0, 4'h0);
      for (int i = 0; i < 9; i++) begin
         cycle();
`ifdef DMEM_ARB_RR_EN
         check("rr_cpu_gnt", gc, (i % 2) == 0);
         check("rr_dbg_gnt", gd, (i % 2) == 1);
`else
         check("fp_cpu_gnt", gc, i == 8);
         check("fp_dbg_gnt", gd, i != 8);
`endif
      end
`ifndef DMEM_ARB_RR_EN
      check("fp_wait_cnt", cpu_wait_cnt, 8);

      // Starvation limit reached while dbg holds the lock: lock wins.
      do_reset();
      set_port(0, 1, 0, 32'h10, 32'h0, 4'h0);
      set_port(1, 1, 1, 32'h30, 32'h55, 4'hF);
      for (int i = 0; i < 10; i++) begin
         dbg_lock = (i >= 7);
         cycle();
         check("lockmax_cpu_gnt", gc, 0);
      end
      dbg_lock = 1'b0;
      set_port(1, 0, 0, 32'h0, 32'h0, 4'h0);
      cycle();
      check("lockmax_release_gnt", gc, 1);
`endif

      // Lock burst: CPU denied past MAX_WAIT, granted once dbg_lock drops.
      do_reset();
      dbg_lock = 1'b1;
      set_port(1, 1, 1, 32'h30, 32'hA0, 4'hF); cycle();
      set_port(0, 1, 0, 32'h10, 32'h0, 4'h0);
      for (int i = 0; i < 9; i++) begin
         set_port(1, i < 5, 1, 32'h30 + 4 * (i % 3), 32'hB0 + i, 4'hF);
         cycle();
         check("lock_cpu_gnt", gc, 0);
      end
      check("lock_wait_cnt", cpu_wait_cnt, 9);
      dbg_lock = 1'b0;
      cycle();
      check("lock_release_gnt", gc, 1);
      set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
      cycle();

      // Reset arriving with a CPU read outstanding.
      set_port(0, 1, 0, 32'h10, 32'h0, 4'h0); cycle();
      check("midrd_gnt", gc, 1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("midrd_no_rvalid", cpu_if.rvalid, 0);
         cycle();
      end

      // Randomized traffic; ungranted payloads are held stable.
      gc = 0; gd = 0;
      for (int i = 0; i < 800; i++) begin
         if (!(cpu_if.req && !gc))
            set_port(0, $urandom_range(0, 9) < 6, 1'($urandom), {26'd0, 4'($urandom), 2'b00},
                     $urandom, 4'($urandom));
         if (!(dbg_if.req && !gd))
            set_port(1, $urandom_range(0, 9) < 6, 1'($urandom), {26'd0, 4'($urandom), 2'b00},
                     $urandom, 4'($urandom));
         if ($urandom_range(0, 7) == 0) dbg_lock = !dbg_lock;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
